// File: rtl/sample_collector_pkg.sv
// rtl/sample_collector_pkg.sv - register map, control bits and record layout for sample_collector
package sample_collector_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h01;
  localparam logic [7:0] REG_DATA   = 8'h02;
  localparam logic [7:0] REG_DROPS  = 8'h03;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CLEAR_BIT  = 1;

  localparam int REC_VAL_BIT = 15;
  localparam int REC_PIN_MSB = 14;
  localparam int REC_PIN_LSB = 8;
  localparam int REC_CNT_MSB = 7;
  localparam int REC_CNT_LSB = 0;

  localparam int REC_PIN_W = REC_PIN_MSB - REC_PIN_LSB + 1;
  localparam int REC_CNT_W = REC_CNT_MSB - REC_CNT_LSB + 1;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - single-clock first-word-fall-through FIFO with synchronous clear
module sample_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & ~empty & ~clr;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sample_collector.sv
// rtl/sample_collector.sv - turns per-pin sample counter changes into FIFO records read over the bus
module sample_collector
  import sample_collector_pkg::*;
#(
  parameter int         NUM_PINS   = 8,
  parameter int         FIFO_DEPTH = 64,
  parameter logic [7:0] POSITION   = 8'hF0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [18:0]            addr,
  input  logic [15:0]            data_in,
  input  logic                   data_wr,
  input  logic                   data_rd,
  output logic [15:0]            data_out,
  input  logic [NUM_PINS-1:0]    pin_sample,
  input  logic [16*NUM_PINS-1:0] pin_sample_cnt
);

  localparam int PIW = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;

  logic                 enable;
  logic                 overflow;
  logic [15:0]          drops;
  logic [NUM_PINS-1:0]  pending;
  logic [NUM_PINS-1:0]  cap_val;
  logic [NUM_PINS-1:0]  evt;
  logic [15:0]          last_cnt [NUM_PINS];
  logic [7:0]           cap_cnt  [NUM_PINS];
  logic [PIW-1:0]       rr_ptr;
  logic [PIW-1:0]       grant_idx;
  logic                 found;
  logic                 grant;
  logic                 rd_d;
  logic [15:0]          rd_addr_d;
  logic [7:0]           drop_n;
  logic [16:0]          drops_sum;
  logic                 sel;
  logic                 ctrl_wr;
  logic                 clear;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LW-1:0]        fifo_level;
  logic [15:0]          fifo_dout;
  logic [15:0]          fifo_din;
  logic                 unused_bits;

  assign unused_bits = ^{data_in[15:2], addr[18:16]};

  assign sel     = (addr[15:8] == POSITION);
  assign ctrl_wr = data_wr & sel & (addr[7:0] == REG_CTRL);
  assign clear   = ctrl_wr & data_in[CTRL_CLEAR_BIT];
  assign pop     = rd_d & ~data_rd & (rd_addr_d == {POSITION, REG_DATA});

  always_comb begin
    for (int i = 0; i < NUM_PINS; i++) begin
      evt[i] = enable && (pin_sample_cnt[16*i +: 16] != last_cnt[i]);
    end
  end

  // Two passes give a rotating priority starting at rr_ptr without modulo arithmetic.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (!found && pending[i] && (PIW'(i) >= rr_ptr)) begin
        found     = 1'b1;
        grant_idx = PIW'(i);
      end
    end
    for (int i = 0; i < NUM_PINS; i++) begin
      if (!found && pending[i]) begin
        found     = 1'b1;
        grant_idx = PIW'(i);
      end
    end
  end

  assign grant    = found & enable & ~fifo_full & ~clear;
  assign fifo_din = {cap_val[grant_idx], REC_PIN_W'(grant_idx), cap_cnt[grant_idx]};

  // A re-pended pin loses its earlier capture unless it is being granted right now.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (evt[i] && pending[i] && !(grant && (grant_idx == PIW'(i)))) drop_n = drop_n + 8'd1;
    end
    drops_sum = {1'b0, drops} + 17'(drop_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      cap_val <= '0;
      for (int i = 0; i < NUM_PINS; i++) begin
        last_cnt[i] <= '0;
        cap_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PINS; i++) begin
        last_cnt[i] <= pin_sample_cnt[16*i +: 16];
        if (evt[i]) begin
          cap_val[i] <= pin_sample[i];
          cap_cnt[i] <= pin_sample_cnt[16*i +: REC_CNT_W];
        end
      end
      if (clear || !enable) begin
        pending <= '0;
      end else begin
        for (int i = 0; i < NUM_PINS; i++) begin
          if (evt[i])                                pending[i] <= 1'b1;
          else if (grant && (grant_idx == PIW'(i)))  pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable    <= 1'b0;
      overflow  <= 1'b0;
      drops     <= '0;
      rr_ptr    <= '0;
      rd_d      <= 1'b0;
      rd_addr_d <= '0;
    end else begin
      rd_d      <= data_rd;
      rd_addr_d <= addr[15:0];
      if (ctrl_wr) enable <= data_in[CTRL_ENABLE_BIT];
      if (clear) begin
        overflow <= 1'b0;
        drops    <= '0;
        rr_ptr   <= '0;
      end else begin
        if (enable && fifo_full && (|pending)) overflow <= 1'b1;
        drops <= drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
        if (grant) rr_ptr <= (grant_idx == PIW'(NUM_PINS-1)) ? '0 : grant_idx + PIW'(1);
      end
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (grant),
    .pop   (pop),
    .clr   (clear),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    data_out = '0;
    if (data_rd && sel) begin
      case (addr[7:0])
        REG_CTRL:   data_out[CTRL_ENABLE_BIT] = enable;
        REG_STATUS: data_out = {overflow, fifo_empty, 14'(fifo_level)};
        REG_DATA:   data_out = fifo_empty ? 16'h0000 : fifo_dout;
        REG_DROPS:  data_out = drops;
        default:    data_out = '0;
      endcase
    end
  end

endmodule
